// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - operation encodings carried on the op input
//   - FSM state encoding
//   - divide-by-zero quotient and last-iteration counter value
package muldiv_pkg;

    localparam int DATA_W = 16;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DZ_QUOTIENT = 16'hFFFF;
    localparam logic [3:0]        STEP_LAST   = 4'd15;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply / divide datapath (purely combinational).
// Ports:
//   op        : OP_MULU or OP_DIVU
//   acc_in    : 17-bit accumulator (MULU: upper product half + carry,
//               DIVU: partial remainder)
//   shreg_in  : 16-bit shift register (MULU: multiplier / low product bits,
//               DIVU: dividend bits in, quotient bits out)
//   operand   : multiplicand (MULU) or divisor (DIVU)
//   acc_out   : accumulator after this iteration
//   shreg_out : shift register after this iteration
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              op,
    input  logic [DATA_W:0]   acc_in,
    input  logic [DATA_W-1:0] shreg_in,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W:0]   acc_out,
    output logic [DATA_W-1:0] shreg_out
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] partial;
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    always_comb begin
        sum       = '0;
        partial   = '0;
        shifted   = '0;
        diff      = '0;
        acc_out   = acc_in;
        shreg_out = shreg_in;

        if (op == OP_MULU) begin
            // acc_in[16] is always zero between steps, so the 17-bit sum
            // captures the carry out of the 16-bit add.
            sum     = acc_in + {1'b0, operand};
            partial = shreg_in[0] ? sum : acc_in;
            // Shift {partial, shreg} right by one as a single 33-bit value.
            acc_out   = {1'b0, partial[DATA_W:1]};
            shreg_out = {partial[0], shreg_in[DATA_W-1:1]};
        end else begin
            // Bring in the next dividend bit, MSB first. The remainder is
            // always below the divisor, so the shifted value fits in 17 bits
            // and bit 16 of the difference is a clean borrow flag.
            shifted = {acc_in[DATA_W-1:0], shreg_in[DATA_W-1]};
            diff    = shifted - {1'b0, operand};
            if (!diff[DATA_W]) begin
                acc_out   = diff;
                shreg_out = {shreg_in[DATA_W-2:0], 1'b1};
            end else begin
                acc_out   = shifted;
                shreg_out = {shreg_in[DATA_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer driving the
// write side of the LO/HI special registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; operands latched when start is accepted
//   S_RUN   | one shift-add / restoring-divide iteration per clock (16)
//   S_WRITE | one cycle: write strobes + done, result on value_lo/hi
//
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   start, op             : request and operation (0 = MULU, 1 = DIVU)
//   operand_a, operand_b  : multiplicand/dividend, multiplier/divisor
//   busy                  : high in RUN and WRITE
//   done, write_lo/hi     : one-cycle pulses in WRITE
//   div_by_zero           : pulse with done when a DIVU had divisor 0
//   value_lo, value_hi    : registered result, held until the next WRITE
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             write_lo,
    output logic             write_hi,
    output logic [WIDTH-1:0] value_lo,
    output logic [WIDTH-1:0] value_hi
);

    localparam int STEPS = WIDTH;
    localparam int CNT_W = $clog2(STEPS);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic               op_q;
    logic               dz_q;
    logic [WIDTH-1:0]   operand_q;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH:0]     acc_nx;
    logic [WIDTH-1:0]   shreg_nx;
    logic               accept;
    logic               start_dz;
    logic               last_step;

    assign accept    = (state == S_IDLE) && start;
    assign start_dz  = (op == OP_DIVU) && (operand_b == '0);
    assign last_step = (count == STEP_LAST);

    muldiv_step u_step (
        .op        (op_q),
        .acc_in    (acc),
        .shreg_in  (shreg),
        .operand   (operand_q),
        .acc_out   (acc_nx),
        .shreg_out (shreg_nx)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = start_dz ? S_WRITE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_WRITE);
        write_lo    = (state == S_WRITE);
        write_hi    = (state == S_WRITE);
        div_by_zero = (state == S_WRITE) && dz_q;
    end

    // Datapath, counter and result registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            op_q      <= OP_MULU;
            dz_q      <= 1'b0;
            operand_q <= '0;
            acc       <= '0;
            shreg     <= '0;
            value_lo  <= '0;
            value_hi  <= '0;
        end else begin
            if (accept) begin
                op_q  <= op;
                dz_q  <= start_dz;
                count <= '0;
                acc   <= '0;
                // MULU iterates over multiplier bits, DIVU over dividend bits.
                if (op == OP_MULU) begin
                    operand_q <= operand_a;
                    shreg     <= operand_b;
                end else begin
                    operand_q <= operand_b;
                    shreg     <= operand_a;
                end
                if (start_dz) begin
                    value_lo <= DZ_QUOTIENT;
                    value_hi <= operand_a;
                end
            end else if (state == S_RUN) begin
                acc   <= acc_nx;
                shreg <= shreg_nx;
                count <= count + 1'b1;
                // Both operations finish with the low result in the shift
                // register and the high result in the accumulator.
                if (last_step) begin
                    value_lo <= shreg_nx;
                    value_hi <= acc_nx[WIDTH-1:0];
                end
            end
        end
    end

endmodule
